prores_bit_packer: RTL

- Parametrised successor to the encoder's fixed-width set_bit stage.
- Accepts variable-length codewords from the DC/AC entropy encoders over a valid/ready handshake and packs them MSB-first into OUT_BYTES-wide output words.
- Adds output backpressure, an explicit flush with zero-padding and a valid-byte count, and a running payload bit counter.
- Sits between the entropy encoders and the slice/frame writer.

---
 rtl/prores_bitstream_pkg.sv | 26 ++
 rtl/prores_bit_append.sv | 29 ++
 rtl/prores_bit_packer.sv | 94 +++++++++
 3 files changed

// File: rtl/prores_bitstream_pkg.sv
// prores_bitstream_pkg: shared types and sizing helpers for the ProRes bitstream packers
// Contents: state_t (RUN/FLUSH), width helpers, ceil-bytes helper, parameter legality check
package prores_bitstream_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic int f_out_w(input int out_bytes);
    return out_bytes * 8;
  endfunction

  function automatic int f_acc_w(input int out_bytes, input int max_code_bits);
    return f_out_w(out_bytes) + max_code_bits;
  endfunction

  function automatic int f_ceil_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

  function automatic bit f_params_ok(input int max_code_bits, input int out_bytes);
    return out_bytes >= 1 && max_code_bits >= 1 && max_code_bits <= f_out_w(out_bytes);
  endfunction

endpackage

// File: rtl/prores_bit_append.sv
// prores_bit_append: masks a right-aligned codeword and appends it MSB-first to a left-aligned accumulator
// i_acc/i_fill: accumulator and its bit count; i_val/i_len: codeword and length (clamped to MAX_CODE_BITS)
// o_acc/o_fill: accumulator and count after the append; o_len: clamped length actually appended
module prores_bit_append #(
  parameter int MAX_CODE_BITS = 32,
  parameter int ACC_W         = 64
) (
  input  logic [ACC_W-1:0]                     i_acc,
  input  logic [$clog2(ACC_W+1)-1:0]           i_fill,
  input  logic [MAX_CODE_BITS-1:0]             i_val,
  input  logic [$clog2(MAX_CODE_BITS+1)-1:0]   i_len,
  output logic [ACC_W-1:0]                     o_acc,
  output logic [$clog2(ACC_W+1)-1:0]           o_fill,
  output logic [$clog2(MAX_CODE_BITS+1)-1:0]   o_len
);
  localparam int LW = $clog2(MAX_CODE_BITS + 1);
  localparam int FW = $clog2(ACC_W + 1);
  logic [MAX_CODE_BITS-1:0] w_mask;
  logic [ACC_W-1:0]         w_ext;
  logic [31:0]              w_sh;
  assign o_len  = i_len > LW'(MAX_CODE_BITS) ? LW'(MAX_CODE_BITS) : i_len;
  // at o_len == MAX_CODE_BITS the shift wraps to 0 and the subtraction yields all ones
  assign w_mask = (MAX_CODE_BITS'(1) << o_len) - MAX_CODE_BITS'(1);
  assign w_ext  = ACC_W'(i_val & w_mask);
  // bits below fill are always zero, so an OR places the codeword right after the held bits
  assign w_sh   = 32'(ACC_W) - 32'(i_fill) - 32'(o_len);
  assign o_acc  = i_acc | (w_ext << w_sh);
  assign o_fill = i_fill + FW'(o_len);
endmodule

// File: rtl/prores_bit_packer.sv
// prores_bit_packer: packs variable-length codewords MSB-first into OUT_BYTES-wide words with flush and backpressure
// CLOCK/RESET: sole clock and asynchronous active-high reset
// in_valid/in_ready/in_val/in_len/in_flush: codeword beat; in_flush ends the stream after this beat
// out_valid/out_ready/out_data/out_bytes/out_last: packed word, valid leading bytes, final word of a stream
// total_bits: payload bits accepted since reset; fill_level: bits held in the accumulator
module prores_bit_packer
  import prores_bitstream_pkg::*;
#(
  parameter int MAX_CODE_BITS = 32,
  parameter int OUT_BYTES     = 4,
  parameter int CNT_BITS      = 64
) (
  input  logic                                                   CLOCK,
  input  logic                                                   RESET,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [MAX_CODE_BITS-1:0]                               in_val,
  input  logic [$clog2(MAX_CODE_BITS+1)-1:0]                     in_len,
  input  logic                                                   in_flush,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [f_out_w(OUT_BYTES)-1:0]                          out_data,
  output logic [$clog2(OUT_BYTES+1)-1:0]                         out_bytes,
  output logic                                                   out_last,
  output logic [CNT_BITS-1:0]                                    total_bits,
  output logic [$clog2(f_acc_w(OUT_BYTES, MAX_CODE_BITS)+1)-1:0] fill_level
);
  localparam int OUT_W = f_out_w(OUT_BYTES);
  localparam int ACC_W = f_acc_w(OUT_BYTES, MAX_CODE_BITS);
  localparam int LW    = $clog2(MAX_CODE_BITS + 1);
  localparam int FW    = $clog2(ACC_W + 1);
  localparam int BW    = $clog2(OUT_BYTES + 1);
  if (!f_params_ok(MAX_CODE_BITS, OUT_BYTES)) begin : g_bad_params
    $error("prores_bit_packer: MAX_CODE_BITS must be in 1..OUT_BYTES*8");
  end
  state_t              r_state;
  logic [ACC_W-1:0]    r_acc, w_acc_in, w_acc_app;
  logic [FW-1:0]       r_fill, w_fill_in, w_fill_app;
  logic [LW-1:0]       w_len;
  logic                r_out_valid, r_out_last;
  logic [OUT_W-1:0]    r_out_data;
  logic [BW-1:0]       r_out_bytes;
  logic [CNT_BITS-1:0] r_total;
  logic                w_free, w_emit, w_final, w_accept;
  assign w_free    = !r_out_valid || out_ready;
  assign w_emit    = w_free && r_fill >= FW'(OUT_W);
  // final word of a flush; takes priority over w_emit when exactly one full word is left so it carries out_last
  assign w_final   = r_state == FLUSH && w_free && r_fill <= FW'(OUT_W);
  assign in_ready  = r_state == RUN && (r_fill < FW'(OUT_W) || w_emit);
  assign w_accept  = in_valid && in_ready;
  assign w_acc_in  = w_emit ? r_acc << OUT_W : r_acc;
  assign w_fill_in = w_emit ? r_fill - FW'(OUT_W) : r_fill;
  prores_bit_append #(
    .MAX_CODE_BITS(MAX_CODE_BITS),
    .ACC_W        (ACC_W)
  ) u_append (
    .i_acc (w_acc_in),
    .i_fill(w_fill_in),
    .i_val (in_val),
    .i_len (in_len),
    .o_acc (w_acc_app),
    .o_fill(w_fill_app),
    .o_len (w_len)
  );
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state     <= RUN;
      r_acc       <= '0;
      r_fill      <= '0;
      r_total     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bytes <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_final ? RUN : (w_accept && in_flush) ? FLUSH : r_state;
      r_acc       <= w_final ? '0 : w_accept ? w_acc_app : w_acc_in;
      r_fill      <= w_final ? '0 : w_accept ? w_fill_app : w_fill_in;
      r_total     <= w_accept ? r_total + CNT_BITS'(w_len) : r_total;
      r_out_valid <= w_final || w_emit || (r_out_valid && !out_ready);
      if (w_final || w_emit) begin
        r_out_data  <= r_acc[ACC_W-1 -: OUT_W];
        r_out_bytes <= w_final ? BW'(f_ceil_bytes(int'(r_fill))) : BW'(OUT_BYTES);
        r_out_last  <= w_final;
      end
    end
  end
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_bytes  = r_out_bytes;
  assign out_last   = r_out_last;
  assign total_bits = r_total;
  assign fill_level = r_fill;
endmodule
